signed_int_to_float: RTL



---
 rtl/fp_pkg.sv | 19 +
 rtl/lzc32.sv | 15 +
 rtl/signed_int_to_float.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants and field layout, used by the
// int/float converters and the FP arithmetic units.
package fp_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_INT_W  = 32;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    // Biased exponent of a value whose leading one sits in bit 31 (2^31).
    localparam logic [FP_EXP_W-1:0] ITOF_EXP_TOP = FP_EXP_W'(FP_BIAS + FP_INT_W - 1);

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for a zero input.
module lzc32 (
    input  logic [31:0] in_val,
    output logic [5:0]  lz
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        lz = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (in_val[i]) lz = 6'(31 - i);
        end
    end

endmodule

// File: rtl/signed_int_to_float.sv
// 3-stage signed int32 -> IEEE-754 single converter with valid/ready handshake.
// Define ITOF_ROUND_RNE_EN for round-to-nearest-even; otherwise truncates toward zero.
module signed_int_to_float
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_int,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_fp,
    output logic        out_inexact
);

    logic adv;

    // S1: sign / magnitude
    logic        v1_q, v1_d;
    logic        sign1_q, sign1_d;
    logic [31:0] mag1_q, mag1_d;

    // S2: normalize
    logic        v2_q, v2_d;
    logic        sign2_q, sign2_d;
    logic [31:0] norm2_q, norm2_d;
    logic [7:0]  exp2_q, exp2_d;
    logic        zero2_q, zero2_d;
    logic [5:0]  lz;

    // S3: round / pack
    logic        out_valid_q, out_valid_d;
    fp32_t       out_fp_q, out_fp_d;
    logic        out_inexact_q, out_inexact_d;

    logic [22:0] frac_t, frac_r;
    logic [7:0]  exp_r;
    logic        guard_b, sticky_b;

    lzc32 u_lzc (
        .in_val (mag1_q),
        .lz     (lz)
    );

    // Whole pipe advances as one; bubbles are kept rather than collapsed.
    always_comb begin
        adv      = !out_valid_q | out_ready;
        in_ready = adv;
    end

    always_comb begin
        frac_t   = norm2_q[30:8];
        guard_b  = norm2_q[7];
        sticky_b = |norm2_q[6:0];
`ifdef ITOF_ROUND_RNE_EN
        begin
            logic inc;
            logic carry;
            inc             = guard_b & (sticky_b | frac_t[0]);
            {carry, frac_r} = {1'b0, frac_t} + {23'd0, inc};
            exp_r           = exp2_q + {7'd0, carry};
        end
`else
        frac_r = frac_t;
        exp_r  = exp2_q;
`endif
    end

    always_comb begin
        v1_d          = v1_q;
        sign1_d       = sign1_q;
        mag1_d        = mag1_q;
        v2_d          = v2_q;
        sign2_d       = sign2_q;
        norm2_d       = norm2_q;
        exp2_d        = exp2_q;
        zero2_d       = zero2_q;
        out_valid_d   = out_valid_q;
        out_fp_d      = out_fp_q;
        out_inexact_d = out_inexact_q;

        if (adv) begin
            v1_d    = in_valid;
            sign1_d = in_int[31];
            mag1_d  = in_int[31] ? (~in_int + 32'd1) : in_int;

            v2_d    = v1_q;
            sign2_d = sign1_q;
            norm2_d = mag1_q << lz;
            exp2_d  = ITOF_EXP_TOP - {2'b00, lz};
            zero2_d = (mag1_q == 32'd0);

            out_valid_d = v2_q;
            if (zero2_q) begin
                out_fp_d      = '0;
                out_inexact_d = 1'b0;
            end else begin
                out_fp_d.sign = sign2_q;
                out_fp_d.exp  = exp_r;
                out_fp_d.frac = frac_r;
                out_inexact_d = guard_b | sticky_b;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            out_valid_q   <= 1'b0;
            out_fp_q      <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            v1_q          <= v1_d;
            v2_q          <= v2_d;
            out_valid_q   <= out_valid_d;
            out_fp_q      <= out_fp_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    // NOTE: interior data registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        sign1_q <= sign1_d;
        mag1_q  <= mag1_d;
        sign2_q <= sign2_d;
        norm2_q <= norm2_d;
        exp2_q  <= exp2_d;
        zero2_q <= zero2_d;
    end

    assign out_valid   = out_valid_q;
    assign out_fp      = out_fp_q;
    assign out_inexact = out_inexact_q;

endmodule
